// File: rtl/aon_lfclk_ctrl.sv
// rtl/aon_lfclk_ctrl.sv - AON low-frequency clock divider controller with boundary-safe reconfiguration
// Optional edge_cnt calibration output enabled by defining LFCLK_CTRL_EDGECNT_EN.
module aon_lfclk_ctrl #(
  parameter int               CNT_W        = 8,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = 8'h7F,
  parameter bit               DEFAULT_EN   = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_en,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             lfclk_out,
  output logic             lfclk_rise,
  output logic             running,
  output logic [CNT_W-1:0] cur_half
`ifdef LFCLK_CTRL_EDGECNT_EN
  ,
  output logic [15:0]      edge_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] pend_half_q, pend_half_d;
  logic             pend_en_q, pend_en_d;
  logic             lfclk_q, lfclk_d;
  logic             rise_q, rise_d;
  logic             ready_q, ready_d;
  logic             accept;
  logic             wrap;
`ifdef LFCLK_CTRL_EDGECNT_EN
  logic [15:0]      edge_cnt_q, edge_cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    half_d      = half_q;
    pend_half_d = pend_half_q;
    pend_en_d   = pend_en_q;
    lfclk_d     = lfclk_q;
    rise_d      = 1'b0;
    ready_d     = ready_q;
    accept      = cfg_valid && ready_q;
    wrap        = (cnt_q == half_q);

    if (accept) begin
      pend_half_d = cfg_half;
      pend_en_d   = cfg_en;
      ready_d     = 1'b0;
    end

    case (state_q)
      ST_OFF: begin
        cnt_d   = '0;
        lfclk_d = 1'b0;
        // ready low while OFF means a request was taken last cycle
        if (!ready_q) begin
          half_d  = pend_half_q;
          ready_d = 1'b1;
          if (pend_en_q) state_d = ST_RUN;
        end
      end
      ST_RUN, ST_PEND: begin
        if (wrap) begin
          cnt_d   = '0;
          lfclk_d = !lfclk_q;
          rise_d  = !lfclk_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (state_q == ST_RUN) begin
          if (accept) state_d = ST_PEND;
        end else if (wrap && lfclk_q) begin
          half_d  = pend_half_q;
          ready_d = 1'b1;
          state_d = pend_en_q ? ST_RUN : ST_OFF;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

`ifdef LFCLK_CTRL_EDGECNT_EN
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (rise_d) edge_cnt_d = edge_cnt_q + 16'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= DEFAULT_EN ? ST_RUN : ST_OFF;
      cnt_q       <= '0;
      half_q      <= DEFAULT_HALF;
      pend_half_q <= '0;
      pend_en_q   <= 1'b0;
      lfclk_q     <= 1'b0;
      rise_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      pend_half_q <= pend_half_d;
      pend_en_q   <= pend_en_d;
      lfclk_q     <= lfclk_d;
      rise_q      <= rise_d;
      ready_q     <= ready_d;
    end
  end

`ifdef LFCLK_CTRL_EDGECNT_EN
  always_ff @(posedge clk) begin
    if (!resetn) edge_cnt_q <= 16'd0;
    else         edge_cnt_q <= edge_cnt_d;
  end
  assign edge_cnt = edge_cnt_q;
`endif

  assign cfg_ready  = ready_q;
  assign lfclk_out  = lfclk_q;
  assign lfclk_rise = rise_q;
  assign running    = (state_q == ST_RUN) || (state_q == ST_PEND);
  assign cur_half   = half_q;

endmodule
